// File: rtl/clock_period_meter.sv
// clock_period_meter
//   Measures the period and high time of a slow asynchronous square wave in
//   system-clock cycles, using a start/done handshake.
//
// Parameters
//   WIDTH        counter and result width
//   SYNC_STAGES  flops in the input synchronizer (2 or more)
//
// Ports
//   clock       system clock, rising edge
//   reset       synchronous active-low reset
//   signalIn    asynchronous square wave to measure
//   start       begin a measurement (only honoured in IDLE)
//   continuous  re-arm after each completed measurement
//   busy        high whenever not IDLE
//   done        one-cycle pulse when the results below update
//   periodOut   cycles between two synchronized rising edges
//   highOut     cycles from that rising edge to the following falling edge
//   overflow    last measurement timed out, results are all ones
module clock_period_meter #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             signalIn,
    input  logic             start,
    input  logic             continuous,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] periodOut,
    output logic [WIDTH-1:0] highOut,
    output logic             overflow
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_LOW  = 2'd1;
    localparam logic [1:0] WAIT_RISE = 2'd2;
    localparam logic [1:0] MEASURE   = 2'd3;

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [SYNC_STAGES-1:0] syncChain;
    logic                   sync;
    logic                   prev;
    logic                   rise;
    logic                   fall;

    logic [1:0]       state;
    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] highReg;
    logic             highSeen;
    logic             timeout;

    // Input synchronizer followed by one extra register for edge detection.
    // Both edges see the same latency, so it cancels out of the results.
    always_ff @(posedge clock) begin
        if (!reset) begin
            syncChain <= '0;
            prev      <= 1'b0;
        end else begin
            syncChain <= {syncChain[SYNC_STAGES-2:0], signalIn};
            prev      <= sync;
        end
    end

    assign sync = syncChain[SYNC_STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

    // A rise in MEASURE completes the measurement and wins over the timeout;
    // otherwise a saturated counter ends the attempt before it could wrap.
    assign timeout = (state != IDLE) && (counter == CNT_MAX) &&
                     !((state == MEASURE) && rise);

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            counter   <= '0;
            highReg   <= '0;
            highSeen  <= 1'b0;
            done      <= 1'b0;
            periodOut <= '0;
            highOut   <= '0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (timeout) begin
                overflow  <= 1'b1;
                periodOut <= CNT_MAX;
                highOut   <= CNT_MAX;
                done      <= 1'b1;
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            counter <= '0;
                            state   <= WAIT_LOW;
                        end
                    end
                    // Skip a high level already present at start so the
                    // first measured rise is a genuine edge.
                    WAIT_LOW: begin
                        counter <= counter + CNT_ONE;
                        if (!sync)
                            state <= WAIT_RISE;
                    end
                    WAIT_RISE: begin
                        if (rise) begin
                            counter  <= CNT_ONE;
                            highSeen <= 1'b0;
                            state    <= MEASURE;
                        end else begin
                            counter <= counter + CNT_ONE;
                        end
                    end
                    MEASURE: begin
                        counter <= counter + CNT_ONE;
                        if (fall && !highSeen) begin
                            highReg  <= counter;
                            highSeen <= 1'b1;
                        end
                        if (rise) begin
                            periodOut <= counter;
                            highOut   <= highReg;
                            overflow  <= 1'b0;
                            done      <= 1'b1;
                            if (continuous) begin
                                // This rise is also the start of the next period.
                                counter  <= CNT_ONE;
                                highSeen <= 1'b0;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_period_meter.sv
module tb_clock_period_meter;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         signalIn = 1'b0;
    logic         start = 1'b0;
    logic         continuous = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] periodOut;
    logic [W-1:0] highOut;
    logic         overflow;

    clock_period_meter #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .signalIn   (signalIn),
        .start      (start),
        .continuous (continuous),
        .busy       (busy),
        .done       (done),
        .periodOut  (periodOut),
        .highOut    (highOut),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        int period;
        int high;
        int ovf;
        int busy;
        int gap;    // expected cycles since previous done, 0 = not checked
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   lastDone = -1;

    // Waveform generator: periodic wh-high/wl-low, or held low/high.
    int wmode = 1;
    int wh = 4;
    int wl = 4;
    int wbase = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clock) cyc++;

    always @(posedge clock) begin
        #1;
        case (wmode)
            0:       signalIn = (((cyc - wbase) % (wh + wl)) < wh);
            1:       signalIn = 1'b0;
            default: signalIn = 1'b1;
        endcase
    end

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clock) begin
        if (reset && done) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: done=1 with no pending result, periodOut=%0d (cycle %0d)",
                         periodOut, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("periodOut", periodOut, e.period);
                chk("highOut", highOut, e.high);
                chk("overflow", overflow, e.ovf);
                chk("busy_at_done", busy, e.busy);
                if (e.gap > 0) chk("done_spacing", cyc - lastDone, e.gap);
            end
            lastDone = cyc;
        end
    end

    task automatic set_wave(input int h, input int l);
        wh = h;
        wl = l;
        wbase = cyc;
        wmode = 0;
    endtask

    task automatic push(input int p, input int h, input int ovf, input int b, input int gap);
        exp_t e;
        e.period = p; e.high = h; e.ovf = ovf; e.busy = b; e.gap = gap;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic do_start();
        @(posedge clock); #2;
        start = 1'b1;
        @(posedge clock); #2;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_empty(input string name, input int maxCyc);
        int n = 0;
        while (q.size() != 0 && n < maxCyc) begin
            @(posedge clock); #2;
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            $display("FAIL %s_timeout: %0d results still pending after %0d cycles", name, q.size(), maxCyc);
            q.delete();
        end
    endtask

    initial begin
        int h, l;

        // Reset state
        idle(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_period", periodOut, 0);
        chk("rst_high", highOut, 0);
        chk("rst_overflow", overflow, 0);
        reset = 1'b1;
        idle(2);

        // Divided clock, toggling every 4 cycles
        set_wave(4, 4);
        idle(7);
        push(8, 4, 0, 0, 0);
        do_start();
        wait_empty("div", 300);
        chk("idle_after_div", busy, 0);

        // Asymmetric wave, then start while the input is high
        set_wave(3, 7);
        idle(5);
        push(10, 3, 0, 0, 0);
        do_start();
        wait_empty("asym", 300);
        begin
            int n = 0;
            while (!signalIn && n < 50) begin idle(1); n++; end
        end
        chk("signal_high_before_start", signalIn, 1);
        push(10, 3, 0, 0, 0);
        do_start();
        wait_empty("asym_high", 300);

        // Random one-shot measurements
        for (int i = 0; i < 6; i++) begin
            h = $urandom_range(1, 15);
            l = $urandom_range(1, 15);
            set_wave(h, l);
            idle($urandom_range(1, 20));
            push(h + l, h, 0, 0, 0);
            do_start();
            wait_empty("rand", 300);
            chk("idle_after_rand", busy, 0);
        end

        // Continuous mode: fixed period 12, then a random period
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin h = 5; l = 7; end
            else begin h = $urandom_range(1, 20); l = $urandom_range(1, 20); end
            set_wave(h, l);
            idle(4);
            continuous = 1'b1;
            for (int i = 0; i < 4; i++) push(h + l, h, 0, 1, (i == 0) ? 0 : h + l);
            do_start();
            wait_empty("cont", 400);
            continuous = 1'b0;
            push(h + l, h, 0, 0, h + l);
            wait_empty("cont_stop", 200);
            chk("idle_after_cont", busy, 0);
        end

        // Timeout with input held low, then held high
        wmode = 1;
        idle(5);
        push(255, 255, 1, 0, 0);
        do_start();
        wait_empty("timeout_low", 400);
        chk("idle_after_timeout", busy, 0);
        wmode = 2;
        idle(5);
        push(255, 255, 1, 0, 0);
        do_start();
        wait_empty("timeout_high", 400);

        // Reset during MEASURE: start in the high phase so the measured
        // period begins about 60 cycles later and lasts another 60.
        set_wave(30, 30);
        begin
            int n = 0;
            while (!signalIn && n < 100) begin idle(1); n++; end
        end
        do_start();
        idle(80);
        chk("busy_before_reset", busy, 1);
        reset = 1'b0;
        idle(1);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_period", periodOut, 0);
        chk("midrst_high", highOut, 0);
        chk("midrst_overflow", overflow, 0);
        reset = 1'b1;
        idle(100);   // any done here is flagged by the monitor

        // A start while busy must not disturb the ongoing measurement
        set_wave(6, 4);
        idle(3);
        push(10, 6, 0, 0, 0);
        do_start();
        idle(5);
        start = 1'b1;
        idle(1);
        start = 1'b0;
        wait_empty("ignored_start", 300);
        idle(40);
        chk("idle_after_ignored_start", busy, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/clock_period_meter.md
# clock_period_meter

Measures the period and high time of a slow, asynchronous square wave (e.g. a divided clock from the frequency divider) in units of the system clock. It is the receiving end of the divider: the divider turns a count into a frequency, and this block turns a frequency back into a count. It sits beside the CPU clocking logic for self-check and bring-up, and is driven by a simple start/done handshake.

## Interface
- `WIDTH`, 32: width of the counter and of the result outputs.
- `SYNC_STAGES`, 2: number of flip-flops in the input synchronizer; minimum 2.

- `clock`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `signalIn`  in  1  asynchronous square wave to measure.
- `start`  in  1  level-sampled request to begin a measurement; accepted only in IDLE.
- `continuous`  in  1  when high at measurement completion, re-arm immediately without a new start.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when `periodOut`, `highOut` and `overflow` are updated.
- `periodOut`  out  WIDTH  clock cycles between two consecutive synchronized rising edges.
- `highOut`  out  WIDTH  clock cycles from that rising edge to the following falling edge.
- `overflow`  out  1  last measurement timed out; results are invalid.

## Operation
- **Synchronizer:** `signalIn` passes through a SYNC_STAGES flip-flop chain, then a `prev` register.
  - rise = sync & ~prev; fall = ~sync & prev.
  - Chain and `prev` reset to 0.
- **States:** IDLE, WAIT_LOW, WAIT_RISE, MEASURE.
- **IDLE:** on `start`, clear counter to 0 and go to WAIT_LOW.
- **WAIT_LOW:** wait for sync==0, which rejects a level already high at start or reset. Then go to WAIT_RISE. Counter increments.
- **WAIT_RISE:** on rise, set counter to 1, clear `highSeen` and go to MEASURE. Otherwise the counter increments.
- **MEASURE:** counter increments each cycle.
  - On fall while `highSeen`==0: latch the counter into an internal high register and set `highSeen`.
  - On rise: `periodOut` <= counter, `highOut` <= high register, `overflow` <= 0, `done` pulses.
    - If `continuous`: counter <= 1, `highSeen` <= 0, stay in MEASURE.
    - Otherwise: go to IDLE.
- **Timeout:** in any non-IDLE state, if the counter equals 2^WIDTH-1 and no terminating rise occurs that cycle:
  - `overflow` <= 1, `periodOut` <= all ones, `highOut` <= all ones, `done` pulses, go to IDLE.
  - `continuous` is ignored on timeout.
- **Other rules:**
  - `start` outside IDLE is ignored.
  - Dropping `continuous` mid-measurement takes effect at the next completion.
- **Arithmetic:** the counter is unsigned WIDTH bits and never wraps; the timeout fires first.
- **Reset values:** `busy` 0, `done` 0, `periodOut` 0, `highOut` 0, `overflow` 0, state IDLE, counter 0.
- **Reset mid-measurement:** everything returns to reset values on the next edge. No `done` pulse is produced and the previous results are cleared.

## Timing
- Input-to-edge-detect latency is SYNC_STAGES+1 cycles. It is identical for both edges, so it cancels in `periodOut` and `highOut`.
- `start` sampled high in IDLE: `busy` is high on the next cycle.
- `done` and the result registers update on the same edge, one cycle after the rise is detected in MEASURE. `done` is high for exactly one cycle.
- In one-shot mode `busy` falls together with the `done` pulse.
- In continuous mode, consecutive `done` pulses are exactly `periodOut` cycles apart.
- Measurement resolution is ±1 cycle for asynchronous inputs. For inputs derived synchronously from `clock`, results are exact.
- Minimum measurable period: 2 cycles. Minimum high time: 1 cycle.

## Test plan
- **Divided-clock input:** drive a square wave from the frequency divider with DIVIDE=3 (toggles every 4 cycles); `start` pulse -> `done` with `periodOut`=8, `highOut`=4, `overflow`=0, `busy` low with `done`.
- **Asymmetric input:** wave high 3 cycles, low 7 cycles -> `periodOut`=10, `highOut`=3. Also hold `signalIn` high when `start` is asserted -> the first high phase is ignored and results are still 10/3.
- **Continuous mode:** `continuous`=1, period 12 -> `done` pulses every 12 cycles with `periodOut`=12. Drop `continuous` -> the next `done` returns the block to IDLE.
- **Timeout:** WIDTH=8, `signalIn` held low, `start` -> after 255 cycles `done` pulses with `overflow`=1 and `periodOut`=`highOut`=8'hFF; block in IDLE.
- **Reset and ignored start:** assert `reset`=0 during MEASURE -> next cycle all outputs 0, no `done`. After release, a `start` issued while `busy` has no effect on the ongoing result.
